// File: rtl/ntt_arith_sequencer.sv
// ntt_arith_sequencer
//   Streams element-wise operand pairs from two coefficient RAM read ports
//   into the NTT arith unit and writes each registered result back to a
//   destination RAM region. Processes one element per cycle, fully pipelined.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     cmd_*                    command handshake (valid/ready), opcode, bases,
//                              element count and modulus
//     rd_a_*, rd_b_*           operand RAM read ports (1-cycle latency)
//     au_*                     arith unit opcode/operands/modulus, au_res back
//     wr_en/wr_addr/wr_data    result RAM write port
//     busy, done, cmd_err      status: in progress, completion pulse,
//                              rejection pulse
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for a command; cmd_ready high
//   RUN   | issuing one read pair per cycle until the last element is read
//   DRAIN | draining the RAM-read and arith-unit stages to the final write
module ntt_arith_sequencer #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_opcode,
    input  logic [AW-1:0] cmd_src_a,
    input  logic [AW-1:0] cmd_src_b,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW:0]   cmd_len,
    input  logic [63:0]   cmd_q,

    output logic          rd_a_en,
    output logic [AW-1:0] rd_a_addr,
    input  logic [63:0]   rd_a_data,
    output logic          rd_b_en,
    output logic [AW-1:0] rd_b_addr,
    input  logic [63:0]   rd_b_data,

    output logic [1:0]    au_opcode,
    output logic [63:0]   au_op_a,
    output logic [63:0]   au_op_b,
    output logic [63:0]   au_op_q,
    input  logic [63:0]   au_res,

    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [63:0]   wr_data,

    output logic          busy,
    output logic          done,
    output logic          cmd_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    state_t      state;
    logic        rd_en;
    logic        stg1_vld;   // operand data is at the arith unit inputs this cycle
    logic [AW:0] rem;        // reads still to issue after the current one

    assign cmd_ready = (state == IDLE);
    assign rd_a_en   = rd_en;
    assign rd_b_en   = rd_en;
    assign au_op_a   = rd_a_data;
    assign au_op_b   = rd_b_data;
    assign wr_data   = au_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            stg1_vld  <= 1'b0;
            wr_en     <= 1'b0;
            rd_a_addr <= '0;
            rd_b_addr <= '0;
            wr_addr   <= '0;
            rem       <= '0;
            au_opcode <= '0;
            au_op_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            done     <= 1'b0;
            cmd_err  <= 1'b0;
            stg1_vld <= rd_en;
            wr_en    <= stg1_vld;
            if (wr_en) begin
                wr_addr <= wr_addr + 1'b1;
            end

            case (state)
                IDLE: begin
                    // busy stays high through the done cycle (set on DRAIN
                    // exit) and drops here unless a new run starts at once.
                    busy <= 1'b0;
                    if (cmd_valid) begin
                        au_opcode <= cmd_opcode;
                        au_op_q   <= cmd_q;
                        rd_a_addr <= cmd_src_a;
                        rd_b_addr <= cmd_src_b;
                        wr_addr   <= cmd_dst;
                        if (cmd_opcode[1] || (cmd_len > MAX_LEN)) begin
                            cmd_err <= 1'b1;
                        end else if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            rd_en <= 1'b1;
                            rem   <= cmd_len - 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (rem != '0) begin
                        rd_a_addr <= rd_a_addr + 1'b1;
                        rd_b_addr <= rd_b_addr + 1'b1;
                        rem       <= rem - 1'b1;
                    end else begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    // Last write is in flight when no further operand is queued.
                    if (wr_en && !stg1_vld) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_arith_sequencer.sv
module tb_ntt_arith_sequencer;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_opcode = '0;
    logic [AW-1:0] cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0;
    logic [AW:0]   cmd_len = '0;
    logic [63:0]   cmd_q = '0;
    logic          rd_a_en, rd_b_en;
    logic [AW-1:0] rd_a_addr, rd_b_addr;
    logic [63:0]   rd_a_data = '0, rd_b_data = '0;
    logic [1:0]    au_opcode;
    logic [63:0]   au_op_a, au_op_b, au_op_q;
    logic [63:0]   au_res = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          busy, done, cmd_err;

    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [63:0]   ld_data = '0;

    logic [63:0]   mem     [0:DEPTH-1];
    logic [63:0]   exp_mem [0:DEPTH-1];

    int n_vec = 0;
    int n_err = 0;

    ntt_arith_sequencer #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .cmd_len(cmd_len), .cmd_q(cmd_q),
        .rd_a_en(rd_a_en), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
        .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
        .au_opcode(au_opcode), .au_op_a(au_op_a), .au_op_b(au_op_b),
        .au_op_q(au_op_q), .au_res(au_res),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Coefficient RAM: two 1-cycle read ports, one write port, plus a bench
    // load port used only while the sequencer is idle.
    always @(posedge clk) begin
        if (rd_a_en) rd_a_data <= mem[rd_a_addr];
        if (rd_b_en) rd_b_data <= mem[rd_b_addr];
        if (wr_en)       mem[wr_addr] <= wr_data;
        else if (ld_en)  mem[ld_addr] <= ld_data;
    end

    // Arith unit stand-in: registered modular add / multiply.
    always @(posedge clk) begin
        logic [127:0] t;
        if (au_op_q == 64'd0)      t = '0;
        else if (au_opcode == 2'd1) t = ({64'd0, au_op_a} * {64'd0, au_op_b}) % {64'd0, au_op_q};
        else                        t = ({64'd0, au_op_a} + {64'd0, au_op_b}) % {64'd0, au_op_q};
        au_res <= t[63:0];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [63:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        exp_mem[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Reference: element i result = (A[sa+i] op B[sb+i]) mod q at dst+i,
    // addresses wrapping modulo the RAM size; only the first n elements.
    task automatic ref_apply(input int op, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                             input logic [AW-1:0] d, input int n, input logic [63:0] q);
        for (int i = 0; i < n; i++) begin
            logic [127:0] a, b, r;
            a = {64'd0, exp_mem[AW'(sa + AW'(i))]};
            b = {64'd0, exp_mem[AW'(sb + AW'(i))]};
            r = (op == 1) ? (a * b) % {64'd0, q} : (a + b) % {64'd0, q};
            exp_mem[AW'(d + AW'(i))] = r[63:0];
        end
    endtask

    // Presents a command at a falling edge; returns at the falling edge of the
    // cycle after the accepting edge.
    task automatic send(input int op, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                        input logic [AW-1:0] d, input int len, input logic [63:0] q);
        cmd_valid = 1'b1; cmd_opcode = 2'(op);
        cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d;
        cmd_len = (AW+1)'(len); cmd_q = q;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Checks the per-cycle timing of a run (k = cycles since first RUN cycle);
    // returns at the falling edge of the done cycle.
    task automatic watch(input int op, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                         input logic [AW-1:0] d, input int len, input logic [63:0] q,
                         input bit jam);
        bit seen = 0;
        for (int k = 0; k < len + 8 && !seen; k++) begin
            chk("rd_a_en", rd_a_en, k < len);
            chk("rd_b_en", rd_b_en, k < len);
            if (k < len) begin
                chk("rd_a_addr", rd_a_addr, AW'(sa + AW'(k)));
                chk("rd_b_addr", rd_b_addr, AW'(sb + AW'(k)));
            end
            chk("wr_en", wr_en, (k >= 2) && (k < len + 2));
            if (k >= 2 && k < len + 2)
                chk("wr_addr", wr_addr, AW'(d + AW'(k - 2)));
            chk("done", done, k == len + 2);
            chk("busy", busy, 1'b1);
            chk("cmd_ready", cmd_ready, k == len + 2);
            chk("au_opcode", au_opcode, 2'(op));
            chk("au_op_q", au_op_q, q);
            if (done) seen = 1;
            if (!seen) begin
                if (jam && k == 0) begin
                    cmd_valid = 1'b1; cmd_opcode = 2'(1 - op); cmd_q = 64'd3; cmd_len = 11'd1;
                end
                if (jam && k == 1) cmd_valid = 1'b0;
                @(negedge clk);
            end
        end
        chk("done_seen", seen, 1'b1);
    endtask

    task automatic chk_mem(input logic [AW-1:0] d, input int len);
        for (int i = 0; i < len; i++)
            chk("mem", mem[AW'(d + AW'(i))], exp_mem[AW'(d + AW'(i))]);
    endtask

    task automatic full_cmd(input int op, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                            input logic [AW-1:0] d, input int len, input logic [63:0] q,
                            input bit jam);
        send(op, sa, sb, d, len, q);
        watch(op, sa, sb, d, len, q, jam);
        ref_apply(op, sa, sb, d, len, q);
        chk_mem(d, len);
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_rd"}, rd_a_en | rd_b_en, 1'b0);
        chk({tag, "_wr"}, wr_en, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ready"}, cmd_ready, 1'b1);
    endtask

    initial begin
        logic [63:0]   q;
        logic [AW-1:0] sa, sb, d;
        int            op, len;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 64'(i);
            exp_mem[i] = 64'(i);
        end

        // Reset state
        repeat (2) @(negedge clk);
        idle_checks("rst");
        chk("rst_done", done, 1'b0);
        chk("rst_err", cmd_err, 1'b0);
        chk("rst_rd_a_addr", rd_a_addr, '0);
        chk("rst_au_op_q", au_op_q, 64'd0);
        chk("rst_au_opcode", au_opcode, 2'd0);
        rst = 1'b0;

        // Random memory fill (small values keep products in range)
        for (int i = 0; i < DEPTH; i++) begin
            ld_en = 1'b1; ld_addr = AW'(i); ld_data = 64'($urandom);
            exp_mem[i] = ld_data;
            @(negedge clk);
        end
        ld_en = 1'b0;

        // 1: ADD q=17; a busy-time command is ignored
        poke(10'h010, 64'd5);  poke(10'h011, 64'd16); poke(10'h012, 64'd0);
        poke(10'h020, 64'd14); poke(10'h021, 64'd1);  poke(10'h022, 64'd0);
        @(negedge clk);
        full_cmd(0, 10'h010, 10'h020, 10'h030, 3, 64'd17, 1'b1);
        chk("t1_d0", mem[10'h030], 64'd2);
        chk("t1_d1", mem[10'h031], 64'd0);
        chk("t1_d2", mem[10'h032], 64'd0);
        @(negedge clk);
        idle_checks("t1_after");

        // 2: MULT q=97
        poke(10'h040, 64'd10); poke(10'h041, 64'd96);
        poke(10'h050, 64'd20); poke(10'h051, 64'd96);
        @(negedge clk);
        full_cmd(1, 10'h040, 10'h050, 10'h060, 2, 64'd97, 1'b0);
        chk("t2_d0", mem[10'h060], 64'd6);
        chk("t2_d1", mem[10'h061], 64'd1);
        @(negedge clk);

        // 3: illegal opcode and over-length
        send(2, 10'h0, 10'h0, 10'h070, 4, 64'd5);
        chk("t3a_err", cmd_err, 1'b1);
        chk("t3a_done", done, 1'b0);
        idle_checks("t3a");
        @(negedge clk);
        chk("t3a_err_pulse", cmd_err, 1'b0);
        idle_checks("t3a_next");
        send(0, 10'h0, 10'h0, 10'h070, DEPTH + 1, 64'd5);
        chk("t3b_err", cmd_err, 1'b1);
        idle_checks("t3b");
        @(negedge clk);
        chk("t3b_err_pulse", cmd_err, 1'b0);
        idle_checks("t3b_next");

        // 4: zero length
        send(0, 10'h0, 10'h0, 10'h070, 0, 64'd5);
        chk("t4_done", done, 1'b1);
        chk("t4_err", cmd_err, 1'b0);
        idle_checks("t4");
        @(negedge clk);
        chk("t4_done_pulse", done, 1'b0);
        idle_checks("t4_next");

        // 5: address wrap, src_a == dst
        full_cmd(0, 10'h3FF, 10'h200, 10'h3FF, 3, 64'd1000003, 1'b0);
        @(negedge clk);

        // Randomized non-overlapping commands
        for (int t = 0; t < 12; t++) begin
            op  = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 40));
            sa  = AW'($urandom_range(256, 460));
            sb  = AW'($urandom_range(500, 700));
            d   = AW'($urandom_range(800, 1023));
            q   = 64'($urandom_range(2, 32'h7FFF_FFFF));
            full_cmd(op, sa, sb, d, len, q, 1'b0);
            if (t % 3 == 0) @(negedge clk);
        end
        @(negedge clk);

        // 6: reset at R+3 of a len=8 run
        d = 10'h100;
        send(0, 10'h120, 10'h140, d, 8, 64'd1009);
        for (int k = 0; k < 3; k++) begin
            chk("t6_rd_en", rd_a_en, 1'b1);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        idle_checks("t6_rst");
        chk("t6_rst_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t6_no_done", done, 1'b0);
            chk("t6_no_wr", wr_en, 1'b0);
            @(negedge clk);
        end
        ref_apply(0, 10'h120, 10'h140, d, 1, 64'd1009);
        chk_mem(d, 8);

        // New command after release, then back-to-back at done
        full_cmd(1, 10'h180, 10'h1A0, 10'h1C0, 5, 64'd65537, 1'b0);
        chk("t6_b2b_ready", cmd_ready, 1'b1);
        full_cmd(0, 10'h181, 10'h1A1, 10'h1E0, 4, 64'd257, 1'b0);
        @(negedge clk);
        idle_checks("t6_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
